// File: rtl/lut_interp_q31_if.sv
// Stream-in / ROM / stream-out bundle for the Q31 LUT interpolator.
// The slave modport is the interpolator; master is the phase source, ROM and sink.
interface lut_interp_q31_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned FRAC_WIDTH  = 16,
  parameter int unsigned PHASE_WIDTH = ADDR_WIDTH + FRAC_WIDTH
);
  logic                   in_valid;
  logic                   in_ready;
  logic [PHASE_WIDTH-1:0] in_phase;
  logic [ADDR_WIDTH-1:0]  rom_addr_a;
  logic [ADDR_WIDTH-1:0]  rom_addr_b;
  logic [DATA_WIDTH-1:0]  rom_dout_a;
  logic [DATA_WIDTH-1:0]  rom_dout_b;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  out_data;

  modport master (
    output in_valid, in_phase, rom_dout_a, rom_dout_b, out_ready,
    input  in_ready, rom_addr_a, rom_addr_b, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_phase, rom_dout_a, rom_dout_b, out_ready,
    output in_ready, rom_addr_a, rom_addr_b, out_valid, out_data
  );
endinterface

// File: rtl/lut_interp_q31.sv
// Phase-to-amplitude front end: dual-port LUT lookup, linear interpolation,
// and a credit-limited FWFT output FIFO (the ROM read path cannot stall).
module lut_interp_q31 #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned FRAC_WIDTH  = 16,
  parameter int unsigned PHASE_WIDTH = ADDR_WIDTH + FRAC_WIDTH,
  parameter bit          WRAP        = 1'b1,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input logic             clk,
  input logic             rst,
  lut_interp_q31_if.slave bus
);
  localparam int unsigned DW1  = DATA_WIDTH + 1;
  localparam int unsigned PW   = DW1 + FRAC_WIDTH + 1;
  localparam int unsigned PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  logic                   accept_c;
  logic                   pop_c;
  logic [ADDR_WIDTH-1:0]  idx_c;
  logic [ADDR_WIDTH-1:0]  addr_b_c;
  logic [ADDR_WIDTH-1:0]  addr_a_q;
  logic [ADDR_WIDTH-1:0]  addr_b_q;
  logic                   s1_valid;
  logic                   s2_valid;
  logic                   s3_valid;
  logic [FRAC_WIDTH-1:0]  frac1;
  logic [FRAC_WIDTH-1:0]  frac2;
  logic signed [DW1-1:0]  diff_c;
  logic signed [PW-1:0]   prod_c;
  logic signed [PW-1:0]   prod3;
  logic [DATA_WIDTH-1:0]  a3;
  logic [DATA_WIDTH-1:0]  y_c;
  logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PTRW-1:0]        wr_ptr;
  logic [PTRW-1:0]        rd_ptr;
  logic [CNTW-1:0]        count;
  logic [CNTW-1:0]        credit;
  logic                   unused_prod_bits;

  // Credit covers every sample in the pipe or the FIFO, so a push never finds it full.
  assign bus.in_ready = !rst && (credit < CNTW'(FIFO_DEPTH));
  assign accept_c     = bus.in_valid && bus.in_ready;
  assign pop_c        = bus.out_valid && bus.out_ready;
  assign idx_c        = bus.in_phase[PHASE_WIDTH-1:FRAC_WIDTH];

  always_comb begin
    addr_b_c = ADDR_WIDTH'(idx_c + 1'b1);
    if (!WRAP && (idx_c == ADDR_MAX)) addr_b_c = ADDR_MAX;
  end

  // diff and product are exact; floor of prod/2^FRAC keeps y between a and b.
  assign diff_c = $signed({bus.rom_dout_b[DATA_WIDTH-1], bus.rom_dout_b})
                - $signed({bus.rom_dout_a[DATA_WIDTH-1], bus.rom_dout_a});
  assign prod_c = PW'(diff_c) * PW'($signed({1'b0, frac2}));
  assign y_c    = a3 + prod3[FRAC_WIDTH +: DATA_WIDTH];
  assign unused_prod_bits = ^{prod3[PW-1:FRAC_WIDTH+DATA_WIDTH], prod3[FRAC_WIDTH-1:0]};

  assign bus.rom_addr_a = addr_a_q;
  assign bus.rom_addr_b = addr_b_q;
  assign bus.out_valid  = (count != '0);
  assign bus.out_data   = mem[rd_ptr];

  // Address / ROM / multiply pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      frac1    <= '0;
      frac2    <= '0;
      prod3    <= '0;
      a3       <= '0;
    end else begin
      s1_valid <= accept_c;
      if (accept_c) begin
        addr_a_q <= idx_c;
        addr_b_q <= addr_b_c;
        frac1    <= bus.in_phase[FRAC_WIDTH-1:0];
      end
      s2_valid <= s1_valid;
      frac2    <= frac1;
      s3_valid <= s2_valid;
      prod3    <= prod_c;
      a3       <= bus.rom_dout_a;
    end
  end

  // Output FIFO and credit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      credit <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (s3_valid) begin
        mem[wr_ptr] <= y_c;
        wr_ptr      <= PTRW'(wr_ptr + 1'b1);
      end
      if (pop_c) rd_ptr <= PTRW'(rd_ptr + 1'b1);
      case ({s3_valid, pop_c})
        2'b10:   count <= CNTW'(count + 1'b1);
        2'b01:   count <= CNTW'(count - 1'b1);
        default: count <= count;
      endcase
      case ({accept_c, pop_c})
        2'b10:   credit <= CNTW'(credit + 1'b1);
        2'b01:   credit <= CNTW'(credit - 1'b1);
        default: credit <= credit;
      endcase
    end
  end
endmodule
